// File: rtl/fifo_get_multi_if.sv
// rtl/fifo_get_multi_if.sv - FIFO read side and core stream bundle for fifo_get_multi
interface fifo_get_multi_if #(
  parameter int NCH = 4,
  parameter int DW  = 16
);
  logic              enable;
  logic [NCH-1:0]    empty;
  logic [NCH*DW-1:0] fifo_data;
  logic [NCH-1:0]    fifo_read_en;
  logic [NCH*DW-1:0] data_out;
  logic [NCH-1:0]    data_valid;

  modport master (
    input  enable, empty, fifo_data,
    output fifo_read_en, data_out, data_valid
  );

  modport slave (
    output enable, empty, fifo_data,
    input  fifo_read_en, data_out, data_valid
  );
endinterface

// File: rtl/fifo_get_multi.sv
// rtl/fifo_get_multi.sv - multi-channel FIFO read handshake with 2-entry skid buffers; optional GET_STATS_EN stall counter
module fifo_get_multi #(
  parameter int NCH  = 4,
  parameter int DW   = 16,
  parameter int GANG = 1
`ifdef GET_STATS_EN
  , parameter int CNT_W = 16
`endif
) (
  input  logic             i_clk,
  input  logic             i_rst,
`ifdef GET_STATS_EN
  input  logic             i_clr_stats,
  output logic [CNT_W-1:0] o_stall_cnt,
`endif
  fifo_get_multi_if.master bus
);

  // Per-channel skid buffer: r_head is what the core sees, r_tail holds the second word.
  logic [1:0]     r_occ [NCH];
  logic [DW-1:0]  r_head [NCH];
  logic [DW-1:0]  r_tail [NCH];
  logic [NCH-1:0] r_inflight;
  logic [NCH-1:0] r_valid;

  logic [NCH-1:0] w_pop;
  logic [NCH-1:0] w_credit;
  logic [NCH-1:0] w_rd_en;
  logic [DW-1:0]  w_word [NCH];

  for (genvar g = 0; g < NCH; g++) begin : g_ch
    assign w_word[g] = bus.fifo_data[g*DW +: DW];
    assign bus.data_out[g*DW +: DW] = r_head[g];
  end

  assign bus.data_valid   = r_valid;
  assign bus.fifo_read_en = w_rd_en;

  // Consumption and credit: a new read may go out only if the word will still fit after this edge.
  always_comb begin
    w_pop    = '0;
    w_credit = '0;
    for (int i = 0; i < NCH; i++) begin
      w_pop[i]    = bus.enable & r_valid[i];
      w_credit[i] = (({1'b0, r_occ[i]} + {2'b00, r_inflight[i]}) - {2'b00, w_pop[i]}) < 3'd2;
    end
  end

  // Read strobe issue; ganged mode reads every channel or none, and reset forces it low at once.
  always_comb begin
    w_rd_en = '0;
    if (GANG != 0) begin
      w_rd_en = {NCH{~i_rst & ~(|bus.empty) & (&w_credit)}};
    end else begin
      w_rd_en = ~bus.empty & w_credit & {NCH{~i_rst}};
    end
  end

  // Buffer update: capture the word read last cycle, advance the head on a pop, keep FIFO order.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      for (int i = 0; i < NCH; i++) begin
        r_occ[i]  <= 2'd0;
        r_head[i] <= '0;
        r_tail[i] <= '0;
      end
      r_inflight <= '0;
      r_valid    <= '0;
    end else begin
      for (int i = 0; i < NCH; i++) begin
        case ({r_inflight[i], w_pop[i]})
          2'b11: begin
            // Push and pop together: occupancy unchanged, new word lands behind the new head.
            if (r_occ[i] == 2'd2) begin
              r_head[i] <= r_tail[i];
              r_tail[i] <= w_word[i];
            end else begin
              r_head[i] <= w_word[i];
            end
          end
          2'b01: begin
            r_head[i]  <= r_tail[i];
            r_occ[i]   <= r_occ[i] - 2'd1;
            r_valid[i] <= (r_occ[i] == 2'd2);
          end
          2'b10: begin
            if (r_occ[i] == 2'd0) begin
              r_head[i] <= w_word[i];
            end else begin
              r_tail[i] <= w_word[i];
            end
            r_occ[i]   <= r_occ[i] + 2'd1;
            r_valid[i] <= 1'b1;
          end
          default: begin
          end
        endcase
        r_inflight[i] <= w_rd_en[i];
      end
    end
  end

`ifdef GET_STATS_EN
  logic [CNT_W-1:0] r_stall_cnt;
  logic             w_starved;

  assign w_starved   = bus.enable & ((GANG != 0) ? ~r_valid[0] : ~(&r_valid));
  assign o_stall_cnt = r_stall_cnt;

  // Saturating count of cycles where the core asked for data and got none; clear wins.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_cnt <= '0;
    end else if (i_clr_stats) begin
      r_stall_cnt <= '0;
    end else if (w_starved && (r_stall_cnt != {CNT_W{1'b1}})) begin
      r_stall_cnt <= r_stall_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end
`endif

endmodule

// File: tb/tb_fifo_get_multi.sv
// tb/tb_fifo_get_multi.sv - directed bench for ganged and independent fifo_get_multi instances
module tb_fifo_get_multi;
  localparam int NCH = 4;
  localparam int DW  = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fifo_get_multi_if #(.NCH(NCH), .DW(DW)) g_bus ();
  fifo_get_multi_if #(.NCH(NCH), .DW(DW)) n_bus ();

  logic [DW-1:0] qg [NCH][$];
  logic [DW-1:0] qn [NCH][$];

`ifdef GET_STATS_EN
  logic        g_clr = 1'b0;
  logic        n_clr = 1'b0;
  logic [15:0] g_cnt;
  logic [3:0]  n_cnt;
`endif

  fifo_get_multi #(.NCH(NCH), .DW(DW), .GANG(1)
`ifdef GET_STATS_EN
    , .CNT_W(16)
`endif
  ) u_gang (
    .i_clk(clk),
    .i_rst(rst),
`ifdef GET_STATS_EN
    .i_clr_stats(g_clr),
    .o_stall_cnt(g_cnt),
`endif
    .bus(g_bus)
  );

  fifo_get_multi #(.NCH(NCH), .DW(DW), .GANG(0)
`ifdef GET_STATS_EN
    , .CNT_W(4)
`endif
  ) u_indep (
    .i_clk(clk),
    .i_rst(rst),
`ifdef GET_STATS_EN
    .i_clr_stats(n_clr),
    .o_stall_cnt(n_cnt),
`endif
    .bus(n_bus)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] rep(input logic [15:0] x);
    return {x, x, x, x};
  endfunction

  task automatic upd_empty();
    for (int i = 0; i < NCH; i++) begin
      g_bus.empty[i] = (qg[i].size() == 0);
      n_bus.empty[i] = (qn[i].size() == 0);
    end
  endtask

  task automatic load_g(input logic [3:0] mask, input logic [15:0] base, input int n);
    for (int i = 0; i < NCH; i++)
      if (mask[i])
        for (int k = 0; k < n; k++) qg[i].push_back(base + 16'(k));
  endtask

  task automatic tick();
    logic [NCH-1:0] rg;
    logic [NCH-1:0] rn;
    #1;
    rg = g_bus.fifo_read_en;
    rn = n_bus.fifo_read_en;
    for (int i = 0; i < NCH; i++) begin
      if (rg[i]) chk("g_rd_nonempty", 64'(qg[i].size() != 0), 64'd1);
      if (rn[i]) chk("n_rd_nonempty", 64'(qn[i].size() != 0), 64'd1);
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < NCH; i++) begin
      if (rg[i] && qg[i].size() != 0) g_bus.fifo_data[i*DW +: DW] = qg[i].pop_front();
      if (rn[i] && qn[i].size() != 0) n_bus.fifo_data[i*DW +: DW] = qn[i].pop_front();
    end
    upd_empty();
    #1;
  endtask

  initial begin
    g_bus.enable = 1'b0;
    n_bus.enable = 1'b0;
    g_bus.fifo_data = '0;
    n_bus.fifo_data = '0;
    load_g(4'hF, 16'h0001, 16);
    upd_empty();
    repeat (2) @(posedge clk);
    #2;
    chk("rst_valid", g_bus.data_valid, 0);
    chk("rst_dout", g_bus.data_out, 0);
    chk("rst_rden", g_bus.fifo_read_en, 0);
    chk("rst_n_valid", n_bus.data_valid, 0);

    // Streaming 16 words per channel in gang mode
    rst = 1'b0;
    g_bus.enable = 1'b1;
    for (int k = 0; k < 16; k++) begin
      #1;
      chk("stream_rden", g_bus.fifo_read_en, 4'hF);
      tick();
      if (k == 0) chk("stream_lat", g_bus.data_valid, 4'h0);
      else begin
        chk("stream_valid", g_bus.data_valid, 4'hF);
        chk("stream_dout", g_bus.data_out, rep(16'(k)));
      end
    end
    #1;
    chk("stream_rden_off", g_bus.fifo_read_en, 0);
    tick();
    chk("stream_last", g_bus.data_out, rep(16'h0010));
    chk("stream_last_v", g_bus.data_valid, 4'hF);
    tick();
    chk("stream_drained", g_bus.data_valid, 4'h0);

    // Stall for 5 cycles mid-stream
    load_g(4'hF, 16'h0021, 10);
    upd_empty();
    tick(); tick(); tick();
    chk("stall_pre", g_bus.data_out, rep(16'h0022));
    g_bus.enable = 1'b0;
    #1;
    chk("stall_rden", g_bus.fifo_read_en, 0);
    repeat (5) begin
      tick();
      chk("stall_hold", g_bus.data_out, rep(16'h0022));
      chk("stall_valid", g_bus.data_valid, 4'hF);
      chk("stall_rden_hold", g_bus.fifo_read_en, 0);
    end
    g_bus.enable = 1'b1;
    #1;
    chk("stall_resume_rden", g_bus.fifo_read_en, 4'hF);
    for (int k = 0; k < 8; k++) begin
      tick();
      chk("stall_seq", g_bus.data_out, rep(16'h0023 + 16'(k)));
      chk("stall_seq_v", g_bus.data_valid, 4'hF);
    end
    tick();
    chk("stall_drained", g_bus.data_valid, 4'h0);

    // Gang blocking on channel 2 empty
    load_g(4'b1011, 16'h0031, 4);
    upd_empty();
    #1;
    chk("gblk_rden", g_bus.fifo_read_en, 0);
    repeat (3) begin
      tick();
      chk("gblk_rden_hold", g_bus.fifo_read_en, 0);
      chk("gblk_valid", g_bus.data_valid, 4'h0);
    end
    load_g(4'b0100, 16'h0031, 4);
    upd_empty();
    #1;
    chk("gblk_resume", g_bus.fifo_read_en, 4'hF);
    tick();
    chk("gblk_lat", g_bus.data_valid, 4'h0);
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("gblk_dout", g_bus.data_out, rep(16'h0031 + 16'(k)));
      chk("gblk_valid_all", g_bus.data_valid, 4'hF);
    end
    tick();
    chk("gblk_drained", g_bus.data_valid, 4'h0);

    // Independent mode: ch0 3 words, ch1 8 words
    for (int k = 0; k < 3; k++) qn[0].push_back(16'h00A1 + 16'(k));
    for (int k = 0; k < 8; k++) qn[1].push_back(16'h00B1 + 16'(k));
    upd_empty();
    n_bus.enable = 1'b1;
    #1;
    chk("ind_rden", n_bus.fifo_read_en, 4'b0011);
    for (int k = 1; k <= 10; k++) begin
      logic [3:0] ev;
      tick();
      ev = {2'b00, (k >= 2 && k <= 9), (k >= 2 && k <= 4)};
      chk("ind_valid", n_bus.data_valid, ev);
      if (ev[0]) chk("ind_d0", n_bus.data_out[15:0], 16'h00A1 + 16'(k - 2));
      if (ev[1]) chk("ind_d1", n_bus.data_out[31:16], 16'h00B1 + 16'(k - 2));
      chk("ind_d23", n_bus.data_out[63:32], 0);
      chk("ind_rd23", n_bus.fifo_read_en[3:2], 0);
    end
    n_bus.enable = 1'b0;

    // Reset while a word is in flight
    load_g(4'hF, 16'h0041, 8);
    upd_empty();
    tick(); tick(); tick();
    g_bus.enable = 1'b0;
    #1;
    chk("rmid_pre", g_bus.data_out, rep(16'h0042));
    rst = 1'b1;
    #1;
    chk("rmid_valid", g_bus.data_valid, 4'h0);
    chk("rmid_dout", g_bus.data_out, 0);
    chk("rmid_rden", g_bus.fifo_read_en, 0);
    for (int i = 0; i < NCH; i++) qg[i].delete();
    upd_empty();
    tick();
    chk("rmid_hold", g_bus.data_valid, 4'h0);
    load_g(4'hF, 16'h0051, 2);
    upd_empty();
    g_bus.enable = 1'b1;
    rst = 1'b0;
    #1;
    chk("rrel_rden", g_bus.fifo_read_en, 4'hF);
    tick();
    chk("rrel_stale", g_bus.data_valid, 4'h0);
    tick();
    chk("rrel_first", g_bus.data_out, rep(16'h0051));
    chk("rrel_first_v", g_bus.data_valid, 4'hF);
    tick();
    chk("rrel_second", g_bus.data_out, rep(16'h0052));
    tick();
    chk("rrel_drained", g_bus.data_valid, 4'h0);

`ifdef GET_STATS_EN
    g_bus.enable = 1'b1;
    n_bus.enable = 1'b1;
    g_clr = 1'b1;
    n_clr = 1'b1;
    tick();
    g_clr = 1'b0;
    n_clr = 1'b0;
    repeat (7) tick();
    chk("stats_cnt7", g_cnt, 16'd7);
    g_clr = 1'b1;
    n_clr = 1'b1;
    tick();
    g_clr = 1'b0;
    n_clr = 1'b0;
    chk("stats_clr", g_cnt, 16'd0);
    chk("stats_clr_n", n_cnt, 4'd0);
    repeat (20) tick();
    chk("stats_cnt20", g_cnt, 16'd20);
    chk("stats_sat", n_cnt, 4'hF);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/fifo_get_multi.md
Name: fifo_get_multi

Overview:
- Parametrised multi-channel FIFO read-side handshake block between NCH upstream input FIFOs and one streaming IPPro core.
- Issues FIFO read strobes, absorbs the 1-cycle FIFO read latency, and presents registered data with a valid/enable handshake to the core.
- Two modes: ganged, where all channels move in lockstep for vector cores, and independent per-channel streams.
- A 2-entry skid buffer per channel gives full throughput with no data loss when the core stalls.

Parameters:
- NCH, 4, number of FIFO channels (1..16).
- DW, 16, data width per channel in bits.
- GANG, 1, 1 = all channels read and consumed together; 0 = each channel independent.
- CNT_W, 16, width of the stall statistics counter (used only with the optional feature).

Ports:
- CLK  input  1  system clock; all state updates on the rising edge.
- RESET  input  1  asynchronous, active-high reset.
- ENABLE  input  1  core ready; a word is consumed on a channel when ENABLE=1 and that channel's DATA_VALID=1.
- EMPTY  input  NCH  per-channel FIFO empty flag.
- FIFO_DATA  input  NCH*DW  per-channel FIFO read data, valid the cycle after FIFO_READ_EN; channel i is bits [i*DW +: DW].
- FIFO_READ_EN  output  NCH  per-channel FIFO read strobe; combinational.
- DATA_OUT  output  NCH*DW  per-channel head-of-buffer data; registered.
- DATA_VALID  output  NCH  per-channel head valid; registered.

Behaviour:
- Per-channel state:
  - occ: 0..2 words held in the skid buffer.
  - inflight: 0..1, set when a read was issued last cycle.
  - 2-entry buffer; DATA_OUT is always the head entry.
- pop[i] = ENABLE & DATA_VALID[i].
- Credit: credit[i] = (occ[i] + inflight[i] - pop[i]) < 2.
- Read issue:
  - Independent mode: FIFO_READ_EN[i] = ~RESET & ~EMPTY[i] & credit[i].
  - Gang mode: all bits = ~RESET & (&~EMPTY) & (&credit). Reads are issued to every channel in the same cycle or to none.
- Capture: if inflight[i]=1 at a clock edge, FIFO_DATA[i] is written into the buffer; inflight[i] then takes the current FIFO_READ_EN[i].
- Latency: FIFO_READ_EN in cycle t -> FIFO_DATA valid in t+1 -> DATA_VALID=1 in t+2 (2 cycles to an empty buffer).
- Throughput: one word per channel per cycle while ENABLE=1 and the FIFO is non-empty.
- Simultaneous push and pop on one edge: the head advances and the pushed word lands behind the new head. occ is unchanged. Word order is strictly FIFO order.
- Stall: when ENABLE=0, DATA_OUT and DATA_VALID hold. At most 2 words are buffered per channel and the read strobe is deasserted before overflow. occ never exceeds 2.
- Empty boundary: EMPTY=1 blocks issue only. Buffered and in-flight words still drain to the core.
- Gang mode:
  - DATA_VALID bits are always all-equal.
  - Any channel empty stalls all channels.
  - pop is common to all channels.
- Reset values, while RESET=1 (regardless of CLK):
  - DATA_VALID=0, DATA_OUT=0.
  - occ=0, inflight=0.
  - FIFO_READ_EN=0.
- Reset mid-operation: in-flight words are dropped. Data presented on FIFO_DATA in the first cycle after RESET deasserts is ignored. Upstream FIFOs are reset by the same RESET.
- Read strobes are never issued to an empty FIFO.

Optional Feature:
- Macro: GET_STATS_EN.
- Defined:
  - Adds input CLR_STATS (1 bit) and output STALL_CNT (CNT_W bits).
  - Increments STALL_CNT on each cycle with ENABLE=1 and the core not served. Gang mode: DATA_VALID[0]=0. Independent mode: any DATA_VALID bit = 0.
  - Saturates at all-ones.
  - Synchronous clear on CLR_STATS=1; clear takes priority over increment.
  - Reset value 0.
- Not defined: no extra ports or logic; behaviour is otherwise identical.

Test Plan:
- Streaming, NCH=4, GANG=1:
  - Stimulus: all FIFOs preloaded with 0x0001..0x0010, ENABLE=1 throughout.
  - Required response: FIFO_READ_EN=4'hF for 16 consecutive cycles. DATA_VALID=4'hF starting 2 cycles after the first read. DATA_OUT sequence 0x0001..0x0010 with no gaps. Then DATA_VALID=0.
- Stall, GANG=1:
  - Stimulus: drop ENABLE for 5 cycles mid-stream.
  - Required response: FIFO_READ_EN=0 within 2 cycles. occ=2, DATA_OUT holds. On ENABLE=1, no word is lost or duplicated, and full rate resumes.
- Gang blocking:
  - Stimulus: EMPTY=4'b0100 while the other FIFOs hold data.
  - Required response: FIFO_READ_EN=0 on all channels. DATA_VALID stays all-equal. Reads resume on all 4 channels the cycle channel 2 becomes non-empty.
- Independent mode, GANG=0:
  - Stimulus: channel 0 holds 3 words, channel 1 holds 8 words, channels 2-3 empty.
  - Required response: channel 0 delivers 3 words and channel 1 delivers 8, each at full rate. FIFO_READ_EN[3:2] is never 1.
- Reset mid-stream:
  - Stimulus: assert RESET asynchronously with inflight=1 and occ=2.
  - Required response: DATA_VALID=0 and FIFO_READ_EN=0 immediately. The stale FIFO_DATA in the first cycle after reset release is not captured.
- GET_STATS_EN:
  - Stimulus: ENABLE=1 with FIFOs empty for 7 cycles, then CLR_STATS pulse.
  - Required response: STALL_CNT=7, then 0 the cycle after the clear. With CNT_W=4 and 20 starved cycles, STALL_CNT saturates at 4'hF.
